// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding select and load-use stall for an in-order pipeline.
// Optional macro FWD_STALL_CNT_EN adds a saturating 32-bit stall_count output.

module fhu_src_lane #(
   parameter int FWD_STAGES = 2,
   parameter int LOAD_LAT   = 1,
   parameter int SEL_W      = 2
) (
   input  logic                       ex_used,
   input  logic [4:0]                 ex_src,
   input  logic                       id_used,
   input  logic [4:0]                 id_src,
   input  logic [FWD_STAGES:0]        stg_vld,
   input  logic [FWD_STAGES:0]        stg_rw,
   input  logic [LOAD_LAT-1:0]        stg_mr,
   input  logic [FWD_STAGES:0][4:0]   stg_rd,
   output logic [SEL_W-1:0]           fwd_sel,
   output logic                       hazard
);
   // Scan oldest to youngest so the youngest matching stage overwrites.
   always_comb begin
      fwd_sel = '0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (ex_used && ex_src != 5'd31 && stg_vld[k] && stg_rw[k] && stg_rd[k] == ex_src)
            fwd_sel = SEL_W'(k);
      end
   end

   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++) begin
         if (id_used && id_src != 5'd31 && stg_vld[k] && stg_rw[k] && stg_mr[k] &&
             stg_rd[k] == id_src)
            hazard = 1'b1;
      end
   end
endmodule

module forwarding_hazard_unit #(
   parameter  int NUM_SRC    = 3,
   parameter  int FWD_STAGES = 2,
   parameter  int LOAD_LAT   = 1,
   localparam int SEL_W      = $clog2(FWD_STAGES+1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       id_valid,
   input  logic [5*NUM_SRC-1:0]       id_src,
   input  logic [NUM_SRC-1:0]         id_src_used,
   input  logic [4:0]                 id_rd,
   input  logic                       id_regwrite,
   input  logic                       id_memread,
   input  logic                       flush,
   output logic [SEL_W*NUM_SRC-1:0]   fwd_sel,
   output logic                       stall
`ifdef FWD_STALL_CNT_EN
   ,output logic [31:0]               stall_count
`endif
);
   typedef struct packed {
      logic [4:0]                rd;
      logic                      regwrite;
      logic                      memread;
      logic [NUM_SRC-1:0][4:0]   src;
      logic [NUM_SRC-1:0]        src_used;
   } trk_t;

   logic [FWD_STAGES:0]        vld_pipe;
   trk_t [FWD_STAGES:0]        trk;
   logic [FWD_STAGES:0][4:0]   stg_rd;
   logic [FWD_STAGES:0]        stg_rw;
   logic [LOAD_LAT-1:0]        stg_mr;
   logic [NUM_SRC-1:0]         hz;
   logic                       unused_trk;

   always_comb begin
      stg_rd = '0;
      stg_rw = '0;
      stg_mr = '0;
      for (int k = 0; k <= FWD_STAGES; k++) begin
         stg_rd[k] = trk[k].rd;
         stg_rw[k] = trk[k].regwrite;
      end
      for (int k = 0; k < LOAD_LAT; k++)
         stg_mr[k] = trk[k].memread;
   end

   // Sources in post-EX stages travel with the entry but are never consulted.
   assign unused_trk = ^trk;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
      fhu_src_lane #(
         .FWD_STAGES (FWD_STAGES),
         .LOAD_LAT   (LOAD_LAT),
         .SEL_W      (SEL_W)
      ) u_lane (
         .ex_used (vld_pipe[0] & trk[0].src_used[i]),
         .ex_src  (trk[0].src[i]),
         .id_used (id_src_used[i]),
         .id_src  (id_src[5*i +: 5]),
         .stg_vld (vld_pipe),
         .stg_rw  (stg_rw),
         .stg_mr  (stg_mr),
         .stg_rd  (stg_rd),
         .fwd_sel (fwd_sel[SEL_W*i +: SEL_W]),
         .hazard  (hz[i])
      );
   end

   assign stall = id_valid & ~flush & (|hz);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         trk      <= '0;
      end else begin
         vld_pipe        <= {vld_pipe[FWD_STAGES-1:0], id_valid & ~stall & ~flush};
         trk[0].rd       <= id_rd;
         trk[0].regwrite <= id_regwrite;
         trk[0].memread  <= id_memread;
         trk[0].src      <= id_src;
         trk[0].src_used <= id_src_used;
         for (int k = 1; k <= FWD_STAGES; k++)
            trk[k] <= trk[k-1];
      end
   end

`ifdef FWD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (stall && stall_count != 32'hFFFF_FFFF)
         stall_count <= stall_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench: a default unit (2 stages, load latency 1) and a 4-stage, load latency 2 unit.
module tb_forwarding_hazard_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [14:0] id_src;
   logic [2:0]  id_src_used;
   logic [4:0]  id_rd;
   logic        id_regwrite, id_memread, flush;
   logic [5:0]  fwd_a;
   logic [8:0]  fwd_b;
   logic        stall_a, stall_b;
`ifdef FWD_STALL_CNT_EN
   logic [31:0] cnt_a, cnt_b;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       v;
      logic [4:0] s0, s1, s2;
      logic [2:0] u;
      logic [4:0] rd;
      logic       rw, mr, fl;
      logic       e_stall;
      logic [8:0] e_fwd;
   } stim_t;

   typedef struct {
      logic       stall;
      logic [8:0] fwd;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   forwarding_hazard_unit u_dut_a (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .flush(flush), .fwd_sel(fwd_a), .stall(stall_a)
`ifdef FWD_STALL_CNT_EN
      , .stall_count(cnt_a)
`endif
   );

   forwarding_hazard_unit #(.NUM_SRC(3), .FWD_STAGES(4), .LOAD_LAT(2)) u_dut_b (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .flush(flush), .fwd_sel(fwd_b), .stall(stall_b)
`ifdef FWD_STALL_CNT_EN
      , .stall_count(cnt_b)
`endif
   );

   function automatic logic [8:0] fa(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      return {3'b000, c[1:0], b[1:0], a[1:0]};
   endfunction

   function automatic logic [8:0] fb(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      return {c, b, a};
   endfunction

   function automatic stim_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] u, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic fl,
                                input logic e_stall, input logic [8:0] e_fwd);
      stim_t s;
      s.v = v; s.s0 = s0; s.s1 = s1; s.s2 = s2; s.u = u; s.rd = rd;
      s.rw = rw; s.mr = mr; s.fl = fl; s.e_stall = e_stall; s.e_fwd = e_fwd;
      return s;
   endfunction

   // Drive one decode slot, record its expectation, and move to the sample point.
   task automatic apply(input stim_t s);
      exp_t e;
      id_valid    = s.v;
      id_src      = {s.s2, s.s1, s.s0};
      id_src_used = s.u;
      id_rd       = s.rd;
      id_regwrite = s.rw;
      id_memread  = s.mr;
      flush       = s.fl;
      e.stall = s.e_stall;
      e.fwd   = s.e_fwd;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic set_idle();
      id_valid = 1'b0; id_src = '0; id_src_used = '0; id_rd = '0;
      id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      exp_t e;
      // Load followed by its use held on the inputs while reset is high.
      reset = 1'b1;
      id_valid = 1'b1; id_src = {5'd31, 5'd4, 5'd4}; id_src_used = 3'b011;
      id_rd = 5'd4; id_regwrite = 1'b1; id_memread = 1'b1; flush = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      apply(mk(1, 4, 4, 31, 3'b011, 5, 1, 0, 0, 0, 9'd0));
      e = sb.pop_front();
      checks++;
      if (stall_a !== e.stall) begin errors++; $display("FAIL reset_stall got %b exp %b", stall_a, e.stall); end
      checks++;
      if (fwd_a !== e.fwd[5:0]) begin errors++; $display("FAIL reset_fwd got %h exp %h", fwd_a, e.fwd[5:0]); end
      checks++;
      if (stall_b !== 1'b0 || fwd_b !== 9'd0) begin
         errors++; $display("FAIL reset_b got stall %b fwd %h exp 0 0", stall_b, fwd_b);
      end
`ifdef FWD_STALL_CNT_EN
      checks++;
      if (cnt_a !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      exp_t  e;
      idle_cycles(3);
      t.push_back(mk(1, 2, 3, 31, 3'b011, 1, 1, 0, 0, 0, fa(0, 0, 0)));  // ADD X1,X2,X3
      t.push_back(mk(1, 1, 3, 31, 3'b011, 2, 1, 0, 0, 0, fa(0, 0, 0)));  // SUB X2,X1,X3
      t.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fa(1, 0, 0)));
      t.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fa(0, 0, 0)));
      for (int j = 0; j < t.size(); j++) begin
         apply(t[j]);
         e = sb.pop_front();
         checks++;
         if (stall_a !== e.stall) begin errors++; $display("FAIL b2b_stall[%0d] got %b exp %b", j, stall_a, e.stall); end
         checks++;
         if (fwd_a !== e.fwd[5:0]) begin errors++; $display("FAIL b2b_fwd[%0d] got %h exp %h", j, fwd_a, e.fwd[5:0]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t t[$];
      exp_t  e;
      idle_cycles(3);
      t.push_back(mk(1, 9, 31, 31, 3'b001, 4, 1, 1, 0, 0, fa(0, 0, 0)));  // LDR X4,[X9]
      t.push_back(mk(1, 4, 4, 31, 3'b011, 5, 1, 0, 0, 1, fa(0, 0, 0)));   // ADD X5,X4,X4 stalls
      t.push_back(mk(1, 4, 4, 31, 3'b011, 5, 1, 0, 0, 0, fa(0, 0, 0)));   // held, bubble in EX
      t.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fa(2, 2, 0)));
      t.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fa(0, 0, 0)));
      for (int j = 0; j < t.size(); j++) begin
         apply(t[j]);
         e = sb.pop_front();
         checks++;
         if (stall_a !== e.stall) begin errors++; $display("FAIL lu_stall[%0d] got %b exp %b", j, stall_a, e.stall); end
         checks++;
         if (fwd_a !== e.fwd[5:0]) begin errors++; $display("FAIL lu_fwd[%0d] got %h exp %h", j, fwd_a, e.fwd[5:0]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_priority_xzr();
      stim_t t[$];
      exp_t  e;
      idle_cycles(3);
      t.push_back(mk(1, 31, 31, 31, 3'b000, 6, 1, 0, 0, 0, fa(0, 0, 0)));   // write X6
      t.push_back(mk(1, 31, 31, 31, 3'b000, 6, 1, 0, 0, 0, fa(0, 0, 0)));   // write X6 again
      t.push_back(mk(1, 6, 6, 6, 3'b111, 10, 1, 0, 0, 0, fa(0, 0, 0)));     // read X6 x3
      t.push_back(mk(1, 31, 31, 31, 3'b000, 31, 1, 0, 0, 0, fa(1, 1, 1)));  // write XZR
      t.push_back(mk(1, 31, 31, 31, 3'b001, 12, 1, 0, 0, 0, fa(0, 0, 0)));  // read XZR
      t.push_back(mk(1, 31, 31, 31, 3'b000, 31, 1, 1, 0, 0, fa(0, 0, 0)));  // load XZR
      t.push_back(mk(1, 31, 31, 31, 3'b001, 13, 1, 0, 0, 0, fa(0, 0, 0)));  // use XZR, no stall
      t.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fa(0, 0, 0)));
      for (int j = 0; j < t.size(); j++) begin
         apply(t[j]);
         e = sb.pop_front();
         checks++;
         if (stall_a !== e.stall) begin errors++; $display("FAIL prio_stall[%0d] got %b exp %b", j, stall_a, e.stall); end
         checks++;
         if (fwd_a !== e.fwd[5:0]) begin errors++; $display("FAIL prio_fwd[%0d] got %h exp %h", j, fwd_a, e.fwd[5:0]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_qualifiers();
      stim_t t[$];
      exp_t  e;
      idle_cycles(3);
      t.push_back(mk(1, 31, 31, 31, 3'b000, 7, 1, 0, 0, 0, fa(0, 0, 0)));   // write X7
      t.push_back(mk(0, 31, 31, 31, 3'b000, 3, 1, 0, 0, 0, fa(0, 0, 0)));   // invalid slot naming X3
      t.push_back(mk(1, 3, 7, 7, 3'b011, 20, 1, 0, 0, 0, fa(0, 0, 0)));     // X7 via stage 2, src2 unused
      t.push_back(mk(1, 31, 31, 31, 3'b000, 8, 0, 0, 0, 0, fa(0, 2, 0)));   // rd X8 without regwrite
      t.push_back(mk(1, 8, 20, 31, 3'b011, 21, 1, 0, 0, 0, fa(0, 0, 0)));
      t.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fa(0, 2, 0)));
      for (int j = 0; j < t.size(); j++) begin
         apply(t[j]);
         e = sb.pop_front();
         checks++;
         if (stall_a !== e.stall) begin errors++; $display("FAIL qual_stall[%0d] got %b exp %b", j, stall_a, e.stall); end
         checks++;
         if (fwd_a !== e.fwd[5:0]) begin errors++; $display("FAIL qual_fwd[%0d] got %h exp %h", j, fwd_a, e.fwd[5:0]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      stim_t t[$];
      exp_t  e;
      idle_cycles(3);
      t.push_back(mk(1, 9, 31, 31, 3'b001, 4, 1, 1, 0, 0, fa(0, 0, 0)));   // LDR X4
      t.push_back(mk(1, 4, 31, 31, 3'b001, 11, 1, 0, 1, 0, fa(0, 0, 0)));  // use X4, flushed
      t.push_back(mk(1, 11, 31, 31, 3'b001, 12, 1, 0, 0, 0, fa(0, 0, 0))); // reads flushed rd
      t.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fa(0, 0, 0)));
      for (int j = 0; j < t.size(); j++) begin
         apply(t[j]);
         e = sb.pop_front();
         checks++;
         if (stall_a !== e.stall) begin errors++; $display("FAIL flush_stall[%0d] got %b exp %b", j, stall_a, e.stall); end
         checks++;
         if (fwd_a !== e.fwd[5:0]) begin errors++; $display("FAIL flush_fwd[%0d] got %h exp %h", j, fwd_a, e.fwd[5:0]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_stall();
      stim_t t[$];
      stim_t p[$];
      exp_t  e;
      idle_cycles(3);
      t.push_back(mk(1, 31, 31, 31, 3'b000, 7, 1, 0, 0, 0, fa(0, 0, 0)));
      t.push_back(mk(1, 31, 31, 31, 3'b000, 8, 1, 0, 0, 0, fa(0, 0, 0)));
      t.push_back(mk(1, 9, 31, 31, 3'b001, 4, 1, 1, 0, 0, fa(0, 0, 0)));
      t.push_back(mk(1, 4, 31, 31, 3'b001, 5, 1, 0, 0, 1, fa(0, 0, 0)));
      for (int j = 0; j < t.size(); j++) begin
         apply(t[j]);
         e = sb.pop_front();
         checks++;
         if (stall_a !== e.stall) begin errors++; $display("FAIL rms_pre_stall[%0d] got %b exp %b", j, stall_a, e.stall); end
         checks++;
         if (fwd_a !== e.fwd[5:0]) begin errors++; $display("FAIL rms_pre_fwd[%0d] got %h exp %h", j, fwd_a, e.fwd[5:0]); end
         if (j < t.size() - 1) begin @(posedge clk); #1; end
      end
      // Reset while the use is still stalled on decode.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      p.push_back(mk(1, 4, 31, 31, 3'b001, 5, 1, 0, 0, 0, fa(0, 0, 0)));
      p.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fa(0, 0, 0)));
      for (int j = 0; j < p.size(); j++) begin
         apply(p[j]);
         e = sb.pop_front();
         checks++;
         if (stall_a !== e.stall) begin errors++; $display("FAIL rms_post_stall[%0d] got %b exp %b", j, stall_a, e.stall); end
         checks++;
         if (fwd_a !== e.fwd[5:0]) begin errors++; $display("FAIL rms_post_fwd[%0d] got %h exp %h", j, fwd_a, e.fwd[5:0]); end
`ifdef FWD_STALL_CNT_EN
         checks++;
         if (cnt_a !== 32'd0) begin errors++; $display("FAIL rms_cnt[%0d] got %0d exp 0", j, cnt_a); end
`endif
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_lat2();
      stim_t t[$];
      exp_t  e;
      set_idle();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      t.push_back(mk(1, 9, 31, 31, 3'b001, 4, 1, 1, 0, 0, fb(0, 0, 0)));   // LDR X4
      t.push_back(mk(1, 4, 31, 31, 3'b001, 5, 1, 0, 0, 1, fb(0, 0, 0)));   // use: load in EX
      t.push_back(mk(1, 4, 31, 31, 3'b001, 5, 1, 0, 0, 1, fb(0, 0, 0)));   // load in stage 1
      t.push_back(mk(1, 4, 31, 31, 3'b001, 5, 1, 0, 0, 0, fb(0, 0, 0)));   // load in stage 2
      t.push_back(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, fb(3, 0, 0)));
      for (int j = 0; j < t.size(); j++) begin
         apply(t[j]);
         e = sb.pop_front();
         checks++;
         if (stall_b !== e.stall) begin errors++; $display("FAIL lat2_stall[%0d] got %b exp %b", j, stall_b, e.stall); end
         checks++;
         if (fwd_b !== e.fwd) begin errors++; $display("FAIL lat2_fwd[%0d] got %h exp %h", j, fwd_b, e.fwd); end
         @(posedge clk); #1;
      end
`ifdef FWD_STALL_CNT_EN
      checks++;
      if (cnt_b !== 32'd2) begin errors++; $display("FAIL lat2_cnt got %0d exp 2", cnt_b); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      set_idle();
      @(posedge clk); #1;
      test_reset();
      test_back_to_back();
      test_load_use();
      test_priority_xzr();
      test_qualifiers();
      test_flush();
      test_reset_mid_stall();
      test_load_lat2();
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_residue got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
